// File: rtl/drive_cmd_arbiter.sv
// drive_cmd_arbiter
// Chooses one of N_SRC driving-command sources for the SimulatedDevice path.
// A neutral gap is inserted whenever the chosen source changes and whenever
// the car would flip directly between forward and backward. Contradictory
// direction pairs are suppressed. Barrier requests become fixed-length pulses.
module drive_cmd_arbiter #(
  parameter int N_SRC      = 3,
  parameter int SEL_W      = 2,
  parameter int SWITCH_GAP = 4,
  parameter int REV_GAP    = 2,
  parameter int PULSE_LEN  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [SEL_W-1:0]   sel,
  input  logic [6*N_SRC-1:0] src_cmd,
  output logic [3:0]         move_signal,
  output logic               place_barrier,
  output logic               destroy_barrier,
  output logic [SEL_W-1:0]   active_src,
  output logic [1:0]         state
);

  // One counter width covers every gap and pulse length.
  localparam int MAX_CNT =
    (SWITCH_GAP > REV_GAP) ?
      ((SWITCH_GAP > PULSE_LEN) ? SWITCH_GAP : PULSE_LEN) :
      ((REV_GAP > PULSE_LEN) ? REV_GAP : PULSE_LEN);
  localparam int CNT_W = $clog2(MAX_CNT) + 1;

  localparam logic [CNT_W-1:0] SWITCH_LOAD = CNT_W'(SWITCH_GAP);
  localparam logic [CNT_W-1:0] REV_LOAD    = CNT_W'(REV_GAP);
  // The start cycle of a pulse is already high, so only PULSE_LEN-1 more remain.
  localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [SEL_W-1:0] MAX_SEL     = SEL_W'(N_SRC);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SWITCH = 2'b01,
    RUN    = 2'b10,
    REV    = 2'b11
  } state_t;

  state_t           st;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] pulse_cnt;
  logic [SEL_W-1:0] cur_sel;
  logic             place_hist;
  logic             destroy_hist;

  logic [5:0]       cmd;
  logic             sel_valid;
  logic             go_switch;
  logic             want_fwd;
  logic             want_bwd;
  logic             want_left;
  logic             want_right;
  logic [3:0]       run_move;
  logic             reversal;
  logic             place_rise;
  logic             destroy_rise;
  logic             pulse_busy;
  logic             start_pulse;

  assign state = st;

  // Pick the 6-bit command word of the source addressed by sel.
  always_comb begin
    cmd = 6'b000000;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel == SEL_W'(i + 1)) begin
        cmd = src_cmd[6*i +: 6];
      end
    end
  end

  // Decode command rules, reversal and barrier edges for the selected source.
  always_comb begin
    sel_valid    = en && (sel != '0) && (sel <= MAX_SEL);
    go_switch    = (st == IDLE) ||
                   ((st == SWITCH) && (sel != cur_sel)) ||
                   (((st == RUN) || (st == REV)) && (sel != active_src));
    want_fwd     = cmd[3] & ~cmd[2];
    want_bwd     = cmd[2] & ~cmd[3];
    want_left    = cmd[1] & ~cmd[0];
    want_right   = cmd[0] & ~cmd[1];
    run_move     = {want_fwd, want_bwd, want_left, want_right};
    reversal     = (move_signal[3] & want_bwd) | (move_signal[2] & want_fwd);
    place_rise   = cmd[4] & ~place_hist;
    destroy_rise = cmd[5] & ~destroy_hist;
    pulse_busy   = place_barrier | destroy_barrier;
    start_pulse  = (st == RUN) && !pulse_busy && (place_rise != destroy_rise);
  end

  // Mode FSM with registered outputs, gap counting and barrier pulse timing.
  always_ff @(posedge clk) begin
    if (reset || !sel_valid) begin
      st              <= IDLE;
      gap_cnt         <= '0;
      pulse_cnt       <= '0;
      cur_sel         <= '0;
      place_hist      <= 1'b0;
      destroy_hist    <= 1'b0;
      move_signal     <= 4'b0000;
      place_barrier   <= 1'b0;
      destroy_barrier <= 1'b0;
      active_src      <= '0;
    end else if (go_switch) begin
      st              <= SWITCH;
      gap_cnt         <= SWITCH_LOAD;
      pulse_cnt       <= '0;
      cur_sel         <= sel;
      place_hist      <= 1'b0;
      destroy_hist    <= 1'b0;
      move_signal     <= 4'b0000;
      place_barrier   <= 1'b0;
      destroy_barrier <= 1'b0;
      active_src      <= '0;
    end else begin
      place_hist   <= cmd[4];
      destroy_hist <= cmd[5];

      case (st)
        SWITCH: begin
          if (gap_cnt <= CNT_ONE) begin
            st         <= RUN;
            gap_cnt    <= '0;
            active_src <= sel;
          end else begin
            gap_cnt <= gap_cnt - CNT_ONE;
          end
        end
        RUN: begin
          if (reversal) begin
            st          <= REV;
            gap_cnt     <= REV_LOAD;
            move_signal <= 4'b0000;
          end else begin
            move_signal <= run_move;
          end
        end
        REV: begin
          if (gap_cnt <= CNT_ONE) begin
            st          <= RUN;
            gap_cnt     <= '0;
            move_signal <= run_move;
          end else begin
            gap_cnt     <= gap_cnt - CNT_ONE;
            move_signal <= 4'b0000;
          end
        end
        default: begin
          st <= IDLE;
        end
      endcase

      if (pulse_busy) begin
        if (pulse_cnt == '0) begin
          place_barrier   <= 1'b0;
          destroy_barrier <= 1'b0;
        end else begin
          pulse_cnt <= pulse_cnt - CNT_ONE;
        end
      end else if (start_pulse) begin
        place_barrier   <= place_rise;
        destroy_barrier <= destroy_rise;
        pulse_cnt       <= PULSE_LOAD;
      end
    end
  end

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// tb_drive_cmd_arbiter
// Randomised and directed stimulus against a behavioural model of the
// arbiter; expected outputs go into a queue and a monitor compares them.
module tb_drive_cmd_arbiter;

  localparam int N_SRC      = 2;
  localparam int SEL_W      = 2;
  localparam int SWITCH_GAP = 4;
  localparam int REV_GAP    = 2;
  localparam int PULSE_LEN  = 3;
  localparam int SRCW       = 6 * N_SRC;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [SEL_W-1:0] sel;
  logic [SRCW-1:0]  src_cmd;
  logic [3:0]       move_signal;
  logic             place_barrier;
  logic             destroy_barrier;
  logic [SEL_W-1:0] active_src;
  logic [1:0]       state;

  always #5 clk = ~clk;

  drive_cmd_arbiter #(
    .N_SRC     (N_SRC),
    .SEL_W     (SEL_W),
    .SWITCH_GAP(SWITCH_GAP),
    .REV_GAP   (REV_GAP),
    .PULSE_LEN (PULSE_LEN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .sel            (sel),
    .src_cmd        (src_cmd),
    .move_signal    (move_signal),
    .place_barrier  (place_barrier),
    .destroy_barrier(destroy_barrier),
    .active_src     (active_src),
    .state          (state)
  );

  typedef struct packed {
    logic [3:0]       move;
    logic             place;
    logic             destroy;
    logic [SEL_W-1:0] act;
    logic [1:0]       st;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  bit   started = 1'b0;

  // Reference model: mode (0 off, 1 gap, 2 run, 3 reversal gap), cycles left.
  int              m_mode;
  int              m_gap_left;
  int              m_target;
  int              m_active;
  int              m_pulse_left;
  logic [3:0]      m_move;
  logic            m_place;
  logic            m_destroy;
  logic [SRCW-1:0] m_prev;

  function automatic logic [5:0] cm(input logic d, input logic p, input logic f,
                                    input logic b, input logic l, input logic r);
    return {d, p, f, b, l, r};
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [SEL_W-1:0] s,
                            input logic [SRCW-1:0] c);
    int         sv;
    int         prev_mode;
    logic [5:0] cur;
    logic [5:0] prv;
    logic       f, b, l, rt, pr, dr;
    sv = int'(s);
    if (r || !e || sv < 1 || sv > N_SRC) begin
      m_mode = 0; m_gap_left = 0; m_target = 0; m_active = 0; m_pulse_left = 0;
      m_move = 4'b0000; m_place = 1'b0; m_destroy = 1'b0;
    end else begin
      cur = c[6*(sv-1) +: 6];
      prv = m_prev[6*(sv-1) +: 6];
      f  = cur[3] && !cur[2];
      b  = cur[2] && !cur[3];
      l  = cur[1] && !cur[0];
      rt = cur[0] && !cur[1];
      if (m_mode == 0 || (m_mode == 1 && sv != m_target) || (m_mode >= 2 && sv != m_active)) begin
        m_mode = 1; m_gap_left = SWITCH_GAP; m_target = sv; m_active = 0;
        m_move = 4'b0000; m_place = 1'b0; m_destroy = 1'b0; m_pulse_left = 0;
      end else if (m_mode == 1) begin
        m_gap_left--;
        if (m_gap_left == 0) begin
          m_mode = 2; m_active = sv;
        end
      end else begin
        prev_mode = m_mode;
        if (m_place || m_destroy) begin
          m_pulse_left--;
          if (m_pulse_left == 0) begin
            m_place = 1'b0; m_destroy = 1'b0;
          end
        end else if (prev_mode == 2) begin
          pr = cur[4] && !prv[4];
          dr = cur[5] && !prv[5];
          if (pr != dr) begin
            m_place = pr; m_destroy = dr; m_pulse_left = PULSE_LEN;
          end
        end
        if (prev_mode == 2) begin
          if ((m_move[3] && b) || (m_move[2] && f)) begin
            m_mode = 3; m_gap_left = REV_GAP; m_move = 4'b0000;
          end else begin
            m_move = {f, b, l, rt};
          end
        end else begin
          m_gap_left--;
          if (m_gap_left == 0) begin
            m_mode = 2; m_move = {f, b, l, rt};
          end else begin
            m_move = 4'b0000;
          end
        end
      end
    end
    m_prev = c;
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [SEL_W-1:0] s,
                               input logic [SRCW-1:0] c);
    exp_t x;
    @(negedge clk);
    reset   = r;
    en      = e;
    sel     = s;
    src_cmd = c;
    model_step(r, e, s, c);
    x.move    = m_move;
    x.place   = m_place;
    x.destroy = m_destroy;
    x.act     = SEL_W'(m_active);
    x.st      = 2'(m_mode);
    exp_q.push_back(x);
    started = 1'b1;
  endtask

  task automatic hold(input logic e, input logic [SEL_W-1:0] s, input logic [5:0] c0,
                      input logic [5:0] c1, input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, e, s, {c1, c0});
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (started) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard_underflow cycle %0d: got empty queue, expected an entry", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("move_signal", 8'(move_signal), 8'(mon_e.move));
        checkOutput("place_barrier", 8'(place_barrier), 8'(mon_e.place));
        checkOutput("destroy_barrier", 8'(destroy_barrier), 8'(mon_e.destroy));
        checkOutput("active_src", 8'(active_src), 8'(mon_e.act));
        checkOutput("state", 8'(state), 8'(mon_e.st));
      end
    end
  end

  initial begin
    logic [SEL_W-1:0] rs;
    logic [SRCW-1:0]  rc;
    logic             re;
    logic             rr;
    logic [5:0]       z;
    reset   = 1'b1;
    en      = 1'b0;
    sel     = '0;
    src_cmd = '0;
    z       = 6'b000000;
    m_prev  = '0;
    model_step(1'b1, 1'b0, '0, '0);

    $display("[TB] reset with arbitrary commands, then bring up source 1");
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 2'd1, SRCW'($urandom));
    hold(1'b1, 2'd1, z, z, 6);

    $display("[TB] direct reversal and stop-then-reverse");
    hold(1'b1, 2'd1, cm(0,0,1,0,0,0), z, 1);
    hold(1'b1, 2'd1, cm(0,0,0,1,0,0), z, 4);
    hold(1'b1, 2'd1, z, z, 1);
    hold(1'b1, 2'd1, cm(0,0,1,0,0,0), z, 2);
    hold(1'b1, 2'd1, z, z, 1);
    hold(1'b1, 2'd1, cm(0,0,0,1,0,0), z, 2);
    hold(1'b1, 2'd1, z, z, 2);

    $display("[TB] contradictory commands");
    hold(1'b1, 2'd1, cm(0,0,1,1,1,1), z, 2);
    hold(1'b1, 2'd1, cm(0,0,1,0,1,0), z, 2);
    hold(1'b1, 2'd1, z, z, 1);

    $display("[TB] barrier pulses");
    hold(1'b1, 2'd1, cm(0,1,0,0,0,0), z, 10);
    hold(1'b1, 2'd1, z, z, 2);
    hold(1'b1, 2'd1, cm(1,1,0,0,0,0), z, 5);
    hold(1'b1, 2'd1, z, z, 2);
    hold(1'b1, 2'd1, cm(1,0,0,0,0,0), z, 5);
    hold(1'b1, 2'd1, z, z, 2);

    $display("[TB] source change mid-pulse with held request");
    hold(1'b1, 2'd1, z, cm(0,1,0,0,0,0), 2);
    hold(1'b1, 2'd1, cm(0,1,0,0,0,0), cm(0,1,0,0,0,0), 2);
    hold(1'b1, 2'd2, cm(0,1,0,0,0,0), cm(0,1,0,0,0,0), 10);
    hold(1'b1, 2'd2, z, z, 1);
    hold(1'b1, 2'd2, z, cm(0,1,0,0,0,0), 5);

    $display("[TB] enable drop and out-of-range select");
    hold(1'b1, 2'd2, z, cm(0,0,1,0,0,0), 2);
    hold(1'b0, 2'd2, z, cm(0,0,1,0,0,0), 2);
    hold(1'b1, 2'd3, z, cm(0,0,1,0,0,0), 4);
    hold(1'b1, 2'd0, z, z, 2);
    hold(1'b1, 2'd1, z, z, 6);

    $display("[TB] randomised traffic");
    rs = 2'd1;
    rc = '0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 7) < 6) rs = SEL_W'($urandom_range(1, N_SRC));
        else rs = SEL_W'($urandom_range(0, 3));
      end
      re = ($urandom_range(0, 59) != 0);
      rr = ($urandom_range(0, 399) == 0);
      for (int b = 0; b < SRCW; b++) begin
        if ($urandom_range(0, 5) == 0) rc[b] = ~rc[b];
      end
      applyStimulus(rr, re, rs, rc);
    end

    @(posedge clk);
    #2;
    started = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
